mem_access_stage: RTL and testbench

//  Memory stage directly downstream of the execute stage. Latches EX results and performs

---
 rtl/mem_pkg.sv | 56 +++++
 rtl/mem_align.sv | 53 +++++
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_pkg;

    // Memory operation decoded in ID and carried down the pipe.
    typedef enum logic [3:0] {
        MemNone = 4'd0,
        MemLb   = 4'd1,
        MemLbu  = 4'd2,
        MemLh   = 4'd3,
        MemLhu  = 4'd4,
        MemLw   = 4'd5,
        MemSb   = 4'd6,
        MemSh   = 4'd7,
        MemSw   = 4'd8
    } mem_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StWaitDiscard,
        StDone
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int unsigned EXC_ADEL_BIT = 4;
    localparam int unsigned EXC_ADES_BIT = 5;

    function automatic logic is_load(mem_op_t op);
        return op inside {MemLb, MemLbu, MemLh, MemLhu, MemLw};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MemSb, MemSh, MemSw};
    endfunction

    function automatic logic is_mem(mem_op_t op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword accesses need bit 0 clear, word accesses need bits 1:0 clear.
    function automatic logic misaligned(mem_op_t op, logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MemLh, MemLhu, MemSh: mis = addr_lo[0];
            MemLw, MemSw:         mis = (addr_lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane handling: store size/replication and load extract/extend.
module mem_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  mem_op_t           op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [1:0]        size_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] load_data_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rd_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Access size and store lanes; narrow stores are replicated so any lane sees the data.
    always_comb begin
        size_o  = SIZE_WORD;
        wdata_o = store_data_i;
        case (op_i)
            MemLb, MemLbu: size_o = SIZE_BYTE;
            MemLh, MemLhu: size_o = SIZE_HALF;
            MemSb: begin
                size_o  = SIZE_BYTE;
                wdata_o = {(DATA_W / 8){store_data_i[7:0]}};
            end
            MemSh: begin
                size_o  = SIZE_HALF;
                wdata_o = {(DATA_W / 16){store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction with sign or zero extension.
    always_comb begin
        load_data_o = rdata_i;
        case (op_i)
            MemLb:   load_data_o = {{(DATA_W - 8){rd_byte[7]}}, rd_byte};
            MemLbu:  load_data_o = {{(DATA_W - 8){1'b0}}, rd_byte};
            MemLh:   load_data_o = {{(DATA_W - 16){rd_half[15]}}, rd_half};
            MemLhu:  load_data_o = {{(DATA_W - 16){1'b0}}, rd_half};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: stage register, split-handshake SRAM FSM, result/forwarding port.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned EXC_W    = 32,
    parameter int unsigned ADEL_BIT = EXC_ADEL_BIT,
    parameter int unsigned ADES_BIT = EXC_ADES_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    input  mem_op_t           mem_op_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [EXC_W-1:0]  exception_type_i,
    input  logic [DATA_W-1:0] current_instr_addr_i,
    output logic              stall_o,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [DATA_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              mem_we_o,
    output logic [REG_AW-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [EXC_W-1:0]  exception_type_o,
    output logic [DATA_W-1:0] bad_vaddr_o,
    output logic [DATA_W-1:0] current_instr_addr_o
);

    mem_state_t        state_q;
    logic              valid_q;
    mem_op_t           op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] store_data_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_AW-1:0] wd_q;
    logic              wreg_q;
    logic [EXC_W-1:0]  exc_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] rdata_q;

    logic              st_mem, st_load, st_store, st_mis, st_err, st_go, ex_go;
    logic [1:0]        al_size;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_load;
    logic [EXC_W-1:0]  exc_add;

    assign st_mem   = is_mem(op_q);
    assign st_load  = is_load(op_q);
    assign st_store = is_store(op_q);
    assign st_mis   = misaligned(op_q, addr_q[1:0]);
    assign st_err   = st_mis || (exc_q != '0);
    // The stage holds a memory op that still has to go out on the bus.
    assign st_go    = valid_q && st_mem && !st_err;
    // Op arriving from EX that can be issued straight out of DONE.
    assign ex_go    = ex_valid_i && is_mem(mem_op_i) && !misaligned(mem_op_i, addr_i[1:0])
                      && (exception_type_i == '0);

    mem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .op_i         (op_q),
        .addr_lo_i    (addr_q[1:0]),
        .store_data_i (store_data_q),
        .rdata_i      (rdata_q),
        .size_o       (al_size),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    // A pending op also stalls while a discarded response is still owed.
    assign stall_o = (state_q == StReq) || (state_q == StWait)
                     || (((state_q == StIdle) || (state_q == StWaitDiscard)) && st_go);

    assign data_req_o   = (state_q == StReq) || ((state_q == StIdle) && st_go && !flush_i);
    assign data_wr_o    = data_req_o && st_store;
    assign data_size_o  = data_req_o ? al_size : 2'd0;
    assign data_addr_o  = data_req_o ? addr_q : '0;
    assign data_wdata_o = (data_req_o && st_store) ? al_wdata : '0;

    // Address-error bits added on top of whatever earlier stages reported.
    always_comb begin
        exc_add = '0;
        if (st_mis) begin
            if (st_load) exc_add[ADEL_BIT] = 1'b1;
            else         exc_add[ADES_BIT] = 1'b1;
        end
    end

    assign mem_we_o    = valid_q && wreg_q && !st_err && !flush_i
                         && (!st_mem || (st_load && (state_q == StDone)));
    assign mem_waddr_o = valid_q ? wd_q : '0;
    assign mem_wdata_o = !valid_q ? '0 : (st_load ? al_load : alu_q);

    assign exception_type_o     = valid_q ? (exc_q | exc_add) : '0;
    assign bad_vaddr_o          = (valid_q && st_mis) ? addr_q : '0;
    assign current_instr_addr_o = valid_q ? pc_q : '0;

    // Stage register: advances when not stalled, cleared by flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            op_q         <= MemNone;
            addr_q       <= '0;
            store_data_q <= '0;
            alu_q        <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            exc_q        <= '0;
            pc_q         <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (!stall_o) begin
            valid_q <= ex_valid_i;
            if (ex_valid_i) begin
                op_q         <= mem_op_i;
                addr_q       <= addr_i;
                store_data_q <= store_data_i;
                alu_q        <= alu_result_i;
                wd_q         <= wd_i;
                wreg_q       <= wreg_i;
                exc_q        <= exception_type_i;
                pc_q         <= current_instr_addr_i;
            end
        end
    end

    // Bus FSM and read-data capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_req_o) begin
                        if (data_addr_ok_i && data_data_ok_i) begin
                            state_q <= StDone;
                            rdata_q <= data_rdata_i;
                        end else if (data_addr_ok_i) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (flush_i) begin
                        // Accepted without its response means one is still owed.
                        state_q <= (data_addr_ok_i && !data_data_ok_i) ? StWaitDiscard : StIdle;
                    end else if (data_addr_ok_i) begin
                        if (data_data_ok_i) begin
                            state_q <= StDone;
                            rdata_q <= data_rdata_i;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (data_data_ok_i) begin
                        if (flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StDone;
                            rdata_q <= data_rdata_i;
                        end
                    end else if (flush_i) begin
                        state_q <= StWaitDiscard;
                    end
                end
                StWaitDiscard: begin
                    if (data_data_ok_i) state_q <= StIdle;
                end
                StDone: begin
                    state_q <= (!flush_i && ex_go) ? StReq : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expectations, a monitor pops them.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    mem_op_t     mem_op_i = MemNone;
    logic [31:0] addr_i = '0, store_data_i = '0, alu_result_i = '0, pc_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] exc_i = '0;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;

    logic        stall_o, data_req_o, data_wr_o, mem_we_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o, mem_wdata_o, exception_type_o, bad_vaddr_o, pc_o;
    logic [4:0]  mem_waddr_o;

    typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} req_t;
    typedef struct {logic [4:0] waddr; logic [31:0] wdata;} wb_t;
    typedef struct {logic [31:0] exc; logic [31:0] bad; logic [31:0] pc;} exc_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    exc_t exc_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .flush_i              (flush_i),
        .ex_valid_i           (ex_valid_i),
        .mem_op_i             (mem_op_i),
        .addr_i               (addr_i),
        .store_data_i         (store_data_i),
        .alu_result_i         (alu_result_i),
        .wd_i                 (wd_i),
        .wreg_i               (wreg_i),
        .exception_type_i     (exc_i),
        .current_instr_addr_i (pc_i),
        .stall_o              (stall_o),
        .data_req_o           (data_req_o),
        .data_wr_o            (data_wr_o),
        .data_size_o          (data_size_o),
        .data_addr_o          (data_addr_o),
        .data_wdata_o         (data_wdata_o),
        .data_addr_ok_i       (addr_ok),
        .data_data_ok_i       (data_ok),
        .data_rdata_i         (rdata),
        .mem_we_o             (mem_we_o),
        .mem_waddr_o          (mem_waddr_o),
        .mem_wdata_o          (mem_wdata_o),
        .exception_type_o     (exception_type_o),
        .bad_vaddr_o          (bad_vaddr_o),
        .current_instr_addr_o (pc_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] alu, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] exc, input logic [31:0] pc);
        ex_valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_data_i = sdata;
        alu_result_i = alu; wd_i = wd; wreg_i = wreg; exc_i = exc; pc_i = pc;
    endtask

    task automatic clear_ex();
        ex_valid_i = 1'b0; mem_op_i = MemNone; exc_i = '0;
    endtask

    // One memory op from an idle stage; addr_ok/data_ok land a_dly/d_dly cycles after entry.
    task automatic mem_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rd, input logic [4:0] wd, input logic wreg,
                           input int a_dly, input int d_dly, output int n_stall);
        drive_ex(op, addr, sdata, 32'h0, wd, wreg, 32'h0, 32'h8000_0000 | addr);
        cycle();
        clear_ex();
        n_stall = 0;
        for (int c = 0; c <= d_dly + 1; c++) begin
            addr_ok = (c == a_dly);
            data_ok = (c == d_dly);
            rdata   = (c == d_dly) ? rd : 32'h0;
            @(negedge clk);
            if (stall_o) n_stall++;
            cycle();
        end
        addr_ok = 1'b0;
        data_ok = 1'b0;
    endtask

    // Op expected to retire with an exception in its single stage cycle.
    task automatic exc_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] exc_in,
                          input logic [31:0] exp_exc, input logic [31:0] exp_bad,
                          input logic [31:0] pc);
        exc_q.push_back('{exp_exc, exp_bad, pc});
        drive_ex(op, addr, 32'h0, 32'h0, 5'd8, 1'b1, exc_in, pc);
        cycle();
        clear_ex();
        @(negedge clk);
        cycle();
    endtask

    // Monitor: compares DUT-presented events against the queued expectations.
    initial begin
        req_t r;
        wb_t  w;
        exc_t e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                if (data_req_o && addr_ok) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req_addr", {32'h0, data_addr_o}, 64'hFFFF_FFFF);
                    end else begin
                        r = req_q.pop_front();
                        check("req_wr", {63'h0, data_wr_o}, {63'h0, r.wr});
                        check("req_size", {62'h0, data_size_o}, {62'h0, r.size});
                        check("req_addr", {32'h0, data_addr_o}, {32'h0, r.addr});
                        if (r.wr) check("req_wdata", {32'h0, data_wdata_o}, {32'h0, r.wdata});
                    end
                end
                if (mem_we_o && !stall_o) begin
                    if (wb_q.size() == 0) begin
                        check("unexpected_wb", {63'h0, mem_we_o}, 64'h0);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_waddr", {59'h0, mem_waddr_o}, {59'h0, w.waddr});
                        check("wb_wdata", {32'h0, mem_wdata_o}, {32'h0, w.wdata});
                    end
                end
                if (exception_type_o != 32'h0) begin
                    if (exc_q.size() == 0) begin
                        check("unexpected_exc", {32'h0, exception_type_o}, 64'h0);
                    end else begin
                        e = exc_q.pop_front();
                        check("exc_type", {32'h0, exception_type_o}, {32'h0, e.exc});
                        check("exc_bad_vaddr", {32'h0, bad_vaddr_o}, {32'h0, e.bad});
                        check("exc_pc", {32'h0, pc_o}, {32'h0, e.pc});
                        check("exc_no_req", {63'h0, data_req_o}, 64'h0);
                        check("exc_no_stall", {63'h0, stall_o}, 64'h0);
                        check("exc_no_we", {63'h0, mem_we_o}, 64'h0);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs_zero", {63'h0, |{stall_o, data_req_o, data_wr_o, data_size_o,
              data_addr_o, data_wdata_o, mem_we_o, mem_waddr_o, mem_wdata_o,
              exception_type_o, bad_vaddr_o, pc_o}}, 64'h0);
        cycle();
        rst_i = 1'b1;
        cycle();

        // Loads
        req_q.push_back('{1'b0, 2'd2, 32'h100, 32'h0});
        wb_q.push_back('{5'd1, 32'hDEAD_BEEF});
        mem_txn(MemLw, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd1, 1'b1, 1, 2, stalls);
        check("lw_stall_cycles", 64'(stalls), 64'd3);

        req_q.push_back('{1'b0, 2'd0, 32'h103, 32'h0});
        wb_q.push_back('{5'd2, 32'hFFFF_FF80});
        mem_txn(MemLb, 32'h103, 32'h0, 32'h8011_2233, 5'd2, 1'b1, 0, 1, stalls);
        check("lb_stall_cycles", 64'(stalls), 64'd2);

        req_q.push_back('{1'b0, 2'd0, 32'h103, 32'h0});
        wb_q.push_back('{5'd3, 32'h0000_0080});
        mem_txn(MemLbu, 32'h103, 32'h0, 32'h8011_2233, 5'd3, 1'b1, 1, 1, stalls);
        check("lbu_same_cycle_stalls", 64'(stalls), 64'd2);

        req_q.push_back('{1'b0, 2'd1, 32'h102, 32'h0});
        wb_q.push_back('{5'd4, 32'hFFFF_8001});
        mem_txn(MemLh, 32'h102, 32'h0, 32'h8001_1234, 5'd4, 1'b1, 0, 2, stalls);

        req_q.push_back('{1'b0, 2'd1, 32'h100, 32'h0});
        wb_q.push_back('{5'd5, 32'h0000_F00F});
        mem_txn(MemLhu, 32'h100, 32'h0, 32'h1234_F00F, 5'd5, 1'b1, 1, 3, stalls);
        check("lhu_stall_cycles", 64'(stalls), 64'd4);

        // Stores
        req_q.push_back('{1'b1, 2'd1, 32'h102, 32'hABCD_ABCD});
        mem_txn(MemSh, 32'h102, 32'h0000_ABCD, 32'h0, 5'd0, 1'b0, 1, 2, stalls);
        req_q.push_back('{1'b1, 2'd0, 32'h101, 32'hA5A5_A5A5});
        mem_txn(MemSb, 32'h101, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 0, 0, stalls);
        check("sb_stall_cycles", 64'(stalls), 64'd1);
        req_q.push_back('{1'b1, 2'd2, 32'h200, 32'h0102_0304});
        mem_txn(MemSw, 32'h200, 32'h0102_0304, 32'h0, 5'd0, 1'b0, 0, 1, stalls);

        // Non-memory pass-through
        wb_q.push_back('{5'd7, 32'h1234_5678});
        drive_ex(MemNone, 32'h55, 32'h0, 32'h1234_5678, 5'd7, 1'b1, 32'h0, 32'h8000_0040);
        cycle();
        clear_ex();
        @(negedge clk);
        check("alu_no_stall", {63'h0, stall_o}, 64'h0);
        cycle();

        // Address errors and inherited exceptions
        exc_op(MemLw, 32'h101, 32'h0, 32'h10, 32'h101, 32'hBFC0_0100);
        exc_op(MemLh, 32'h201, 32'h0, 32'h10, 32'h201, 32'hBFC0_0104);
        exc_op(MemSw, 32'h102, 32'h0, 32'h20, 32'h102, 32'hBFC0_0108);
        exc_op(MemNone, 32'h0, 32'h400, 32'h400, 32'h0, 32'hBFC0_010C);
        exc_op(MemLw, 32'h300, 32'h400, 32'h400, 32'h0, 32'hBFC0_0110);

        // Back-to-back loads: second one issues out of DONE
        req_q.push_back('{1'b0, 2'd2, 32'h500, 32'h0});
        wb_q.push_back('{5'd11, 32'hA0A0_A0A0});
        req_q.push_back('{1'b0, 2'd2, 32'h504, 32'h0});
        wb_q.push_back('{5'd12, 32'h0B0B_0B0B});
        drive_ex(MemLw, 32'h500, 32'h0, 32'h0, 5'd11, 1'b1, 32'h0, 32'h8000_0500);
        cycle(); clear_ex();
        addr_ok = 1'b1; cycle(); addr_ok = 1'b0;
        data_ok = 1'b1; rdata = 32'hA0A0_A0A0; cycle(); data_ok = 1'b0;
        drive_ex(MemLw, 32'h504, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0, 32'h8000_0504);
        cycle(); clear_ex();
        addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0B0B_0B0B;
        @(negedge clk);
        check("b2b_req_from_done", {63'h0, data_req_o}, 64'h1);
        cycle(); addr_ok = 1'b0; data_ok = 1'b0;
        cycle();

        // Flush after addr_ok: response swallowed, next load waits for it, then completes
        req_q.push_back('{1'b0, 2'd2, 32'h400, 32'h0});
        drive_ex(MemLw, 32'h400, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8000_0400);
        cycle(); clear_ex();
        addr_ok = 1'b1; cycle(); addr_ok = 1'b0;
        flush_i = 1'b1; cycle(); flush_i = 1'b0;
        @(negedge clk);
        check("discard_no_stall", {63'h0, stall_o}, 64'h0);
        drive_ex(MemLw, 32'h404, 32'h0, 32'h0, 5'd10, 1'b1, 32'h0, 32'h8000_0404);
        cycle(); clear_ex();
        data_ok = 1'b1; rdata = 32'h1111_1111;
        @(negedge clk);
        check("no_req_while_owed", {63'h0, data_req_o}, 64'h0);
        check("stall_while_owed", {63'h0, stall_o}, 64'h1);
        cycle(); data_ok = 1'b0;
        req_q.push_back('{1'b0, 2'd2, 32'h404, 32'h0});
        wb_q.push_back('{5'd10, 32'hCAFE_F00D});
        addr_ok = 1'b1; cycle(); addr_ok = 1'b0;
        data_ok = 1'b1; rdata = 32'hCAFE_F00D; cycle(); data_ok = 1'b0;
        cycle();

        // Reset while waiting for data
        req_q.push_back('{1'b0, 2'd2, 32'h600, 32'h0});
        drive_ex(MemLw, 32'h600, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0, 32'h8000_0600);
        cycle(); clear_ex();
        addr_ok = 1'b1; cycle(); addr_ok = 1'b0;
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("reset_mid_wait_zero", {63'h0, |{stall_o, data_req_o, data_wr_o, data_size_o,
              data_addr_o, data_wdata_o, mem_we_o, mem_waddr_o, mem_wdata_o,
              exception_type_o, bad_vaddr_o, pc_o}}, 64'h0);
        cycle();
        rst_i = 1'b1;
        cycle();
        req_q.push_back('{1'b0, 2'd2, 32'h700, 32'h0});
        wb_q.push_back('{5'd14, 32'h7654_3210});
        mem_txn(MemLw, 32'h700, 32'h0, 32'h7654_3210, 5'd14, 1'b1, 1, 2, stalls);
        check("post_reset_lw_stalls", 64'(stalls), 64'd3);

        repeat (3) cycle();
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        check("exc_queue_drained", 64'(exc_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
